// File: rtl/vpu_pkg.sv
// Shared VPU definitions used by the element sequencer.
//   - SEW encodings as carried on the width buses
//   - sew_bits(): encoding -> element width in bits (unknown encodings act as 8)
//   - seq_state_e: element sequencer FSM states
package vpu_pkg;

    localparam logic [2:0] SEW8  = 3'b000;
    localparam logic [2:0] SEW16 = 3'b101;
    localparam logic [2:0] SEW32 = 3'b110;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    function automatic logic [5:0] sew_bits(input logic [2:0] enc);
        case (enc)
            SEW16:   sew_bits = 6'd16;
            SEW32:   sew_bits = 6'd32;
            default: sew_bits = 6'd8;
        endcase
    endfunction

endpackage

// File: rtl/vector_element_sequencer.sv
// Bit-serial vector element walker.
// Steps element indices 0..vl-1 at the latched SEW, one element bit per cycle, and
// stops early when the alignment decoder flags the last element of the register.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             begin a sequence (sampled only while idle)
//   i_width, i_vl       SEW encoding and element count for the sequence
//   i_stall             freeze counters and suppress strobes this cycle
//   i_last_index        decoder flag: current index is VLMAX-1
//   o_element_index     current element index (to decoder)
//   o_bit_cnt, o_width  bit position within element, latched SEW encoding
//   o_bit_valid, o_first_bit, o_last_bit, o_word_load   per-bit strobes
//   o_busy, o_done      sequence in progress, one-cycle completion pulse
module vector_element_sequencer
    import vpu_pkg::*;
#(
    parameter int unsigned VLEN = 256,
    parameter int unsigned VL_W = $clog2(VLEN / 8) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_width,
    input  logic [VL_W-1:0] i_vl,
    input  logic            i_stall,
    input  logic            i_last_index,
    output logic [31:0]     o_element_index,
    output logic [4:0]      o_bit_cnt,
    output logic [2:0]      o_width,
    output logic            o_bit_valid,
    output logic            o_first_bit,
    output logic            o_last_bit,
    output logic            o_word_load,
    output logic            o_busy,
    output logic            o_done
);

    seq_state_e      state_q, state_d;
    logic [31:0]     index_q, index_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      width_q, width_d;
    logic [VL_W-1:0] vl_q, vl_d;

    logic [4:0]  sew_last;
    logic [31:0] vl_last;
    logic        last_bit_pos;
    logic        final_elem;
    logic        sub_index_zero;

    assign sew_last     = 5'(sew_bits(width_q) - 6'd1);
    // vl_q is never zero while running, so the subtraction cannot wrap when used.
    assign vl_last      = 32'(vl_q) - 32'd1;
    assign last_bit_pos = (bit_cnt_q == sew_last);
    // The decoder flag clamps vl to VLMAX for the latched width.
    assign final_elem   = (index_q == vl_last) || i_last_index;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            index_q   <= '0;
            bit_cnt_q <= '0;
            width_q   <= '0;
            vl_q      <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            bit_cnt_q <= bit_cnt_d;
            width_q   <= width_d;
            vl_q      <= vl_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        bit_cnt_d = bit_cnt_q;
        width_d   = width_q;
        vl_d      = vl_q;
        case (state_q)
            StIdle: begin
                index_d   = '0;
                bit_cnt_d = '0;
                if (i_start) begin
                    width_d = i_width;
                    vl_d    = i_vl;
                    state_d = (i_vl != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (!i_stall) begin
                    if (last_bit_pos) begin
                        bit_cnt_d = '0;
                        if (final_elem) begin
                            state_d = StDone;
                        end else begin
                            index_d = index_q + 32'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                index_d   = '0;
                bit_cnt_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: depends on registered state and i_stall only.
    always_comb begin
        case (width_q)
            SEW16:   sub_index_zero = ~index_q[0];
            SEW32:   sub_index_zero = 1'b1;
            default: sub_index_zero = (index_q[1:0] == 2'b00);
        endcase
        o_bit_valid = (state_q == StRun) && !i_stall;
        o_first_bit = o_bit_valid && (bit_cnt_q == 5'd0);
        o_last_bit  = o_bit_valid && last_bit_pos;
        o_word_load = o_first_bit && sub_index_zero;
        o_busy      = (state_q == StRun) || (state_q == StDone);
        o_done      = (state_q == StDone);
    end

    assign o_element_index = index_q;
    assign o_bit_cnt       = bit_cnt_q;
    assign o_width         = width_q;

endmodule

// File: tb/tb_vector_element_sequencer.sv
module tb_vector_element_sequencer;

    localparam int unsigned VLEN = 256;
    localparam int unsigned VL_W = $clog2(VLEN / 8) + 1;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_start;
    logic [2:0]      i_width;
    logic [VL_W-1:0] i_vl;
    logic            i_stall;
    logic            i_last_index;
    logic [31:0]     o_element_index;
    logic [4:0]      o_bit_cnt;
    logic [2:0]      o_width;
    logic            o_bit_valid;
    logic            o_first_bit;
    logic            o_last_bit;
    logic            o_word_load;
    logic            o_busy;
    logic            o_done;

    int unsigned vectors;
    int unsigned miscompares;

    vector_element_sequencer #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_width         (i_width),
        .i_vl            (i_vl),
        .i_stall         (i_stall),
        .i_last_index    (i_last_index),
        .o_element_index (o_element_index),
        .o_bit_cnt       (o_bit_cnt),
        .o_width         (o_width),
        .o_bit_valid     (o_bit_valid),
        .o_first_bit     (o_first_bit),
        .o_last_bit      (o_last_bit),
        .o_word_load     (o_word_load),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int unsigned sew_of(input logic [2:0] enc);
        case (enc)
            3'b101:  return 16;
            3'b110:  return 32;
            default: return 8;
        endcase
    endfunction

    // Alignment decoder stand-in: flags the last element of a VLEN-bit register.
    assign i_last_index = (o_element_index == 32'(VLEN / sew_of(o_width) - 1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int unsigned idx, input int unsigned bitc,
                             input bit valid, input bit first, input bit last, input bit wl,
                             input bit busy, input bit done);
        check({tag, ".index"}, o_element_index, 32'(idx));
        check({tag, ".bit_cnt"}, 32'(o_bit_cnt), 32'(bitc));
        check({tag, ".bit_valid"}, 32'(o_bit_valid), 32'(valid));
        check({tag, ".first_bit"}, 32'(o_first_bit), 32'(first));
        check({tag, ".last_bit"}, 32'(o_last_bit), 32'(last));
        check({tag, ".word_load"}, 32'(o_word_load), 32'(wl));
        check({tag, ".busy"}, 32'(o_busy), 32'(busy));
        check({tag, ".done"}, 32'(o_done), 32'(done));
    endtask

    // One sequence checked cycle by cycle against the element/bit walk the spec describes.
    // stall_at/stall_len: forced stall burst at a given bit ordinal; stall_pct: random stalls;
    // abort_at >= 0: apply reset mid-cycle after that bit ordinal is presented.
    task automatic run_seq(input string tag, input logic [2:0] enc, input int unsigned vl,
                           input int stall_at, input int unsigned stall_len,
                           input int unsigned stall_pct, input int abort_at);
        int unsigned sew, vlmax, vl_eff, total, ptr, e, b, stalls_left, guard;
        bit          stall, valid;
        sew    = sew_of(enc);
        vlmax  = VLEN / sew;
        vl_eff = (vl < vlmax) ? vl : vlmax;
        total  = vl_eff * sew;
        stalls_left = stall_len;

        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_width = enc;
        i_vl    = VL_W'(vl);
        i_stall = 1'b0;
        @(negedge i_clk);
        // No combinational path from the start request.
        check_all({tag, ".start"}, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge i_clk); #1;
        i_start = 1'b0;

        ptr   = 0;
        guard = 0;
        while (ptr < total && guard < 4 * total + stall_len + 16) begin
            guard++;
            stall = 1'b0;
            if (stall_at >= 0 && ptr == 32'(stall_at) && stalls_left > 0) begin
                stall = 1'b1;
                stalls_left--;
            end else if ($urandom_range(99) < stall_pct) begin
                stall = 1'b1;
            end
            i_stall = stall;
            i_start = 1'($urandom_range(1));
            i_width = 3'($urandom_range(7));
            @(negedge i_clk);
            e     = ptr / sew;
            b     = ptr % sew;
            valid = !stall;
            check_all({tag, ".run"}, e, b, valid, valid && b == 0, valid && b == sew - 1,
                      valid && b == 0 && ((e * sew) % 32) == 0, 1, 0);
            check({tag, ".width"}, 32'(o_width), 32'(enc));
            if (abort_at >= 0 && valid && ptr == 32'(abort_at)) begin
                #2 i_rst_n = 1'b0;
                #1;
                check_all({tag, ".abort"}, 0, 0, 0, 0, 0, 0, 0, 0);
                check({tag, ".abort_width"}, 32'(o_width), 32'd0);
                i_start = 1'b0;
                i_stall = 1'b0;
                @(posedge i_clk);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge i_clk);
                    check_all({tag, ".post_abort"}, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                return;
            end
            if (valid) ptr++;
            @(posedge i_clk); #1;
        end
        check({tag, ".walk_bound"}, 32'(ptr), 32'(total));

        i_stall = 1'b0;
        i_start = 1'($urandom_range(1));
        @(negedge i_clk);
        check_all({tag, ".done"}, (vl_eff > 0) ? vl_eff - 1 : 0, 0, 0, 0, 0, 0, 1, 1);
        if (vl != 0) check({tag, ".done_width"}, 32'(o_width), 32'(enc));
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        check_all({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [2:0] encs [4];
        vectors     = 0;
        miscompares = 0;
        encs[0] = 3'b000;
        encs[1] = 3'b101;
        encs[2] = 3'b110;
        encs[3] = 3'b011;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_width = 3'b000;
        i_vl    = '0;
        i_stall = 1'b0;

        #2;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.width", 32'(o_width), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all("reset_release", 0, 0, 0, 0, 0, 0, 0, 0);

        run_seq("sew8_vl3", 3'b000, 3, -1, 0, 0, -1);
        run_seq("sew32_vl2", 3'b110, 2, -1, 0, 0, -1);
        run_seq("sew16_vl40_clamp", 3'b101, 40, -1, 0, 0, -1);
        run_seq("sew8_vl5_stall", 3'b000, 5, 12, 3, 0, -1);
        run_seq("vl0", 3'b000, 0, -1, 0, 0, -1);
        run_seq("sew32_vl9_clamp", 3'b110, 9, -1, 0, 0, -1);
        run_seq("abort", 3'b000, 5, -1, 0, 0, 19);
        run_seq("after_abort", 3'b000, 5, -1, 0, 0, -1);

        for (int n = 0; n < 8; n++) begin
            run_seq("random", encs[$urandom_range(3)], $urandom_range(40), -1, 0, 20, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
